// File: rtl/rgb_to_ycbcr.sv
// rgb_to_ycbcr: 3-stage RGB888 -> YCbCr444 converter, BT.601 studio or full range.
// Stage 1 products, stage 2 pos/neg sums, stage 3 clamp into registered outputs.
module rgb_to_ycbcr #(
  parameter bit FULL_RANGE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_r_8b,
  input  logic [7:0] i_g_8b,
  input  logic [7:0] i_b_8b,
  input  logic       i_h_sync,
  input  logic       i_v_sync,
  input  logic       i_data_en,
  output logic [7:0] o_y_8b,
  output logic [7:0] o_cb_8b,
  output logic [7:0] o_cr_8b,
  output logic       o_h_sync,
  output logic       o_v_sync,
  output logic       o_data_en
);

  localparam logic [7:0] K_YR  = FULL_RANGE ? 8'd77  : 8'd66;
  localparam logic [7:0] K_YG  = FULL_RANGE ? 8'd150 : 8'd129;
  localparam logic [7:0] K_YB  = FULL_RANGE ? 8'd29  : 8'd25;
  localparam logic [7:0] K_CBR = FULL_RANGE ? 8'd43  : 8'd38;
  localparam logic [7:0] K_CBG = FULL_RANGE ? 8'd85  : 8'd74;
  localparam logic [7:0] K_CBB = FULL_RANGE ? 8'd128 : 8'd112;
  localparam logic [7:0] K_CRR = FULL_RANGE ? 8'd128 : 8'd112;
  localparam logic [7:0] K_CRG = FULL_RANGE ? 8'd107 : 8'd94;
  localparam logic [7:0] K_CRB = FULL_RANGE ? 8'd21  : 8'd18;

  // Offsets already include the +128 round-half-up term.
  localparam logic [17:0] Y_OFF = FULL_RANGE ? 18'd128 : 18'd4224;
  localparam logic [17:0] C_OFF = 18'd32896;

  logic [8:0][15:0] prod_d, prod_q;
  logic [2:0][17:0] pos_d, pos_q;
  logic [2:0][17:0] neg_d, neg_q;
  logic [7:0]       y_d, y_q;
  logic [7:0]       cb_d, cb_q;
  logic [7:0]       cr_d, cr_q;
  logic [2:0]       hs_d, hs_q;
  logic [2:0]       vs_d, vs_q;
  logic [2:0]       de_d, de_q;
  logic             live1_d, live1_q;
  logic             live2_d, live2_q;

  function automatic logic [15:0] mul8(
    input logic [7:0] a,
    input logic [7:0] k
  );
    return {8'd0, a} * {8'd0, k};
  endfunction

  function automatic logic [17:0] ext(input logic [15:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [7:0] clamp8(
    input logic [17:0] p,
    input logic [17:0] n
  );
    logic [17:0] d;
    d = p - n;
    if (p < n) begin
      clamp8 = 8'd0;
    end else if (d[17:16] != 2'b00) begin
      clamp8 = 8'd255;
    end else begin
      clamp8 = d[15:8];
    end
  endfunction

  always_comb begin
    prod_d[0] = mul8(i_r_8b, K_YR);
    prod_d[1] = mul8(i_g_8b, K_YG);
    prod_d[2] = mul8(i_b_8b, K_YB);
    prod_d[3] = mul8(i_r_8b, K_CBR);
    prod_d[4] = mul8(i_g_8b, K_CBG);
    prod_d[5] = mul8(i_b_8b, K_CBB);
    prod_d[6] = mul8(i_r_8b, K_CRR);
    prod_d[7] = mul8(i_g_8b, K_CRG);
    prod_d[8] = mul8(i_b_8b, K_CRB);

    pos_d[0] = ext(prod_q[0]) + ext(prod_q[1])
             + ext(prod_q[2]) + Y_OFF;
    neg_d[0] = '0;
    pos_d[1] = ext(prod_q[5]) + C_OFF;
    neg_d[1] = ext(prod_q[3]) + ext(prod_q[4]);
    pos_d[2] = ext(prod_q[6]) + C_OFF;
    neg_d[2] = ext(prod_q[7]) + ext(prod_q[8]);

    // Sums left over from reset carry offsets; keep them off the outputs.
    y_d  = live2_q ? clamp8(pos_q[0], neg_q[0]) : 8'd0;
    cb_d = live2_q ? clamp8(pos_q[1], neg_q[1]) : 8'd0;
    cr_d = live2_q ? clamp8(pos_q[2], neg_q[2]) : 8'd0;

    live1_d = 1'b1;
    live2_d = live1_q;

    hs_d = {hs_q[1:0], i_h_sync};
    vs_d = {vs_q[1:0], i_v_sync};
    de_d = {de_q[1:0], i_data_en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      y_q     <= '0;
      cb_q    <= '0;
      cr_q    <= '0;
      hs_q    <= '0;
      vs_q    <= '0;
      de_q    <= '0;
      live1_q <= 1'b0;
      live2_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      y_q     <= y_d;
      cb_q    <= cb_d;
      cr_q    <= cr_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      live1_q <= live1_d;
      live2_q <= live2_d;
    end
  end

  assign o_y_8b    = y_q;
  assign o_cb_8b   = cb_q;
  assign o_cr_8b   = cr_q;
  assign o_h_sync  = hs_q[2];
  assign o_v_sync  = vs_q[2];
  assign o_data_en = de_q[2];

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// tb_rgb_to_ycbcr: studio and full-range instances fed the same stream,
// checked against colour-bar constants and an integer model.
module tb_rgb_to_ycbcr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] r, g, b;
  logic       hs, vs, de;
  logic [7:0] y0, cb0, cr0, y1, cb1, cr1;
  logic       hs0, vs0, de0, hs1, vs1, de1;

  always #5 clk = ~clk;

  rgb_to_ycbcr #(.FULL_RANGE(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .i_r_8b(r), .i_g_8b(g), .i_b_8b(b),
    .i_h_sync(hs), .i_v_sync(vs), .i_data_en(de),
    .o_y_8b(y0), .o_cb_8b(cb0), .o_cr_8b(cr0),
    .o_h_sync(hs0), .o_v_sync(vs0), .o_data_en(de0)
  );

  rgb_to_ycbcr #(.FULL_RANGE(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .i_r_8b(r), .i_g_8b(g), .i_b_8b(b),
    .i_h_sync(hs), .i_v_sync(vs), .i_data_en(de),
    .o_y_8b(y1), .o_cb_8b(cb1), .o_cr_8b(cr1),
    .o_h_sync(hs1), .o_v_sync(vs1), .o_data_en(de1)
  );

  typedef struct {
    int   y0, cb0, cr0;
    int   y1, cb1, cr1;
    logic h, v, de;
    bit   grey;
  } exp_t;

  typedef struct {
    logic [7:0] r, g, b;
    int         y0, cb0, cr0;
    int         y1, cb1, cr1;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   prev_y = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  function automatic int sat(input int s);
    int q;
    if (s < 0) return 0;
    q = s / 256;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic exp_t model(
    input int r_i, input int g_i, input int b_i,
    input logic h_i, input logic v_i, input logic d_i
  );
    exp_t e;
    e.y0  = sat(66*r_i + 129*g_i + 25*b_i + 4096 + 128);
    e.cb0 = sat(-38*r_i - 74*g_i + 112*b_i + 32768 + 128);
    e.cr0 = sat(112*r_i - 94*g_i - 18*b_i + 32768 + 128);
    e.y1  = sat(77*r_i + 150*g_i + 29*b_i + 128);
    e.cb1 = sat(-43*r_i - 85*g_i + 128*b_i + 32768 + 128);
    e.cr1 = sat(128*r_i - 107*g_i - 21*b_i + 32768 + 128);
    e.h = h_i;
    e.v = v_i;
    e.de = d_i;
    e.grey = 1'b0;
    return e;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, int'(y0 | cb0 | cr0 | y1 | cb1 | cr1), 0);
    chk({tag, "_strobes"}, int'({hs0, vs0, de0, hs1, vs1, de1}), 0);
  endtask

  // One pixel per clock; an output is due two calls after its own.
  task automatic apply(
    input logic [7:0] pr, input logic [7:0] pg,
    input logic [7:0] pb, input exp_t e
  );
    exp_t x;
    r = pr;
    g = pg;
    b = pb;
    hs = e.h;
    vs = e.v;
    de = e.de;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 3) begin
      x = exp_q.pop_front();
      chk("y_studio", int'(y0), x.y0);
      chk("cb_studio", int'(cb0), x.cb0);
      chk("cr_studio", int'(cr0), x.cr0);
      chk("y_full", int'(y1), x.y1);
      chk("cb_full", int'(cb1), x.cb1);
      chk("cr_full", int'(cr1), x.cr1);
      chk("h_sync", int'({hs0, hs1}), int'({x.h, x.h}));
      chk("v_sync", int'({vs0, vs1}), int'({x.v, x.v}));
      chk("data_en", int'({de0, de1}), int'({x.de, x.de}));
      if (x.grey) begin
        chk("grey_monotonic", int'(y0 >= 8'(prev_y)), 1);
        prev_y = int'(y0);
      end
    end else begin
      check_zero("fill");
    end
  endtask

  task automatic rand_pixel();
    exp_t e;
    int pr, pg, pb;
    pr = int'($urandom_range(0, 255));
    pg = int'($urandom_range(0, 255));
    pb = int'($urandom_range(0, 255));
    e = model(pr, pg, pb, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    apply(8'(pr), 8'(pg), 8'(pb), e);
  endtask

  initial begin
    vec_t tbl[6];
    exp_t e;

    tbl[0] = '{8'd0,   8'd0,   8'd0,   16,  128, 128, 0,   128, 128};
    tbl[1] = '{8'd255, 8'd255, 8'd255, 235, 128, 128, 255, 128, 128};
    tbl[2] = '{8'd255, 8'd0,   8'd0,   82,  90,  240, 77,  85,  255};
    tbl[3] = '{8'd0,   8'd255, 8'd0,   144, 54,  34,  149, 43,  21};
    tbl[4] = '{8'd0,   8'd0,   8'd255, 41,  240, 110, 29,  255, 107};
    tbl[5] = '{8'd255, 8'd255, 8'd0,   210, 16,  146, 226, 1,   149};

    rst_n = 1'b0;
    r = '0;
    g = '0;
    b = '0;
    hs = 1'b0;
    vs = 1'b0;
    de = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      e = model(0, 0, 0, 1'b0, 1'b0, 1'b1);
      e.y0  = tbl[i].y0;
      e.cb0 = tbl[i].cb0;
      e.cr0 = tbl[i].cr0;
      e.y1  = tbl[i].y1;
      e.cb1 = tbl[i].cb1;
      e.cr1 = tbl[i].cr1;
      apply(tbl[i].r, tbl[i].g, tbl[i].b, e);
    end

    for (int n = 0; n < 64 * 4; n++) begin
      rand_pixel();
    end

    // Asynchronous reset between edges with the pipeline full.
    #3 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      rand_pixel();
    end

    for (int v = 0; v < 256; v++) begin
      e = model(v, v, v, 1'b0, 1'b0, 1'b1);
      e.grey = 1'b1;
      apply(8'(v), 8'(v), 8'(v), e);
    end
    rand_pixel();
    rand_pixel();
    chk("grey_top", prev_y, 235);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_to_ycbcr.md
Name: rgb_to_ycbcr

Overview:
- Pipelined RGB888 to YCbCr444 colour-space converter; the forward-direction counterpart of the YCbCr-to-RGB stage in the image path.
- Sits between the pixel source (camera/test pattern) and YCbCr-domain processing: filtering, thresholding, compression front-end.
- Fixed-point x256 coefficients, 3-cycle pipeline, sync/enable strobes delayed to stay aligned with pixel data.

Parameters:
- FULL_RANGE, 0, 0 = BT.601 studio range (Y 16..235, C 16..240); 1 = BT.601 full range (JPEG, 0..255).

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_r_8b  in  8  red
- i_g_8b  in  8  green
- i_b_8b  in  8  blue
- i_h_sync  in  1  horizontal sync, passed through
- i_v_sync  in  1  vertical sync, passed through
- i_data_en  in  1  pixel valid, passed through
- o_y_8b  out  8  luma
- o_cb_8b  out  8  blue-difference chroma
- o_cr_8b  out  8  red-difference chroma
- o_h_sync  out  1  i_h_sync delayed 3 cycles
- o_v_sync  out  1  i_v_sync delayed 3 cycles
- o_data_en  out  1  i_data_en delayed 3 cycles

Behaviour:
- Reset:
  - rst_n low asynchronously clears every pipeline register and all outputs to 0.
  - Reset asserted mid-stream discards all in-flight pixels.
  - After release, outputs remain 0 until the first real input reaches the output 3 cycles later.
- Coefficients (x256), signed sums:
  - FULL_RANGE=0:
    - Y = 66R+129G+25B+4096
    - Cb = -38R-74G+112B+32768
    - Cr = 112R-94G-18B+32768
  - FULL_RANGE=1:
    - Y = 77R+150G+29B
    - Cb = -43R-85G+128B+32768
    - Cr = 128R-107G-21B+32768
- Stage 1: register nine unsigned 8x8 products, 16 bit each.
- Stage 2: per channel, register the positive-term sum (including constant offset and +128 rounding) and the negative-term sum, 18 bit unsigned each.
- Stage 3: per channel:
  - If pos < neg, output 0.
  - Otherwise diff = pos - neg; if diff[17:16] != 0, output 255; else output diff[15:8].
  - The result is registered directly into o_*_8b (outputs are registered, not combinational).
- Latency: exactly 3 clk from input to o_y/o_cb/o_cr.
  - o_h_sync/o_v_sync/o_data_en use the same 3-cycle delay, so an output pixel and its strobes appear on the same cycle.
- Throughput: one pixel per clock, no stalls, no backpressure.
- Data is converted every cycle regardless of i_data_en. Blanking pixels are converted too; downstream qualifies with o_data_en.
- Rounding is round-half-up via the +128 term before truncation by >>8.
- Saturation applies independently per channel. Full-range Cb/Cr can reach 256 and must clamp to 255.
- Simultaneous sync edges and data_en toggles carry no special handling; the three strobes are pure 3-stage shift registers.

Test Plan:
- Reset then black (0,0,0), FULL_RANGE=0, data_en=1 -> 3 cycles later Y/Cb/Cr=16/128/128, o_data_en=1 on that same cycle.
- FULL_RANGE=0 colour bars:
  - White (255,255,255) -> 235/128/128
  - Red (255,0,0) -> 82/90/240
  - Green (0,255,0) -> 144/54/34
  - Blue (0,0,255) -> 41/240/110
  - Yellow (255,255,0) -> 210/16/146
- FULL_RANGE=1:
  - White -> 255/128/128
  - Blue (0,0,255) -> 29/255/107 (Cb clamped from 256)
  - Red -> 77/85/255 (Cr clamped)
  - Black -> 0/128/128
- Back-to-back random pixels with random h/v/data_en over a 64x4 frame -> every output matches a golden integer model at cycle n+3; strobe outputs equal inputs delayed 3 cycles, with no bubble and no misalignment.
- Assert rst_n low asynchronously between clock edges mid-line with a full pipeline -> all outputs 0 immediately. After release, the first 3 outputs are the converted post-reset inputs only, with no stale data.
- Sweep R=G=B=0..255 (grey ramp), FULL_RANGE=0 -> Cb=Cr=128 for all inputs; Y monotonic non-decreasing from 16 to 235.
